// File: rtl/multi_digit_counter.sv
// Cascaded BCD up/down counter with registered zero flag and one-cycle wrap pulse.
// Define MDC_LOAD_EN to enable the synchronous load with per-digit clamp to 9.
module multi_digit_counter #(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    zero,
    output logic                    wrap
);
    localparam int unsigned W = 4 * NUM_DIGITS;

    logic [W-1:0] count_nxt;
    logic         wrap_nxt;
    logic         ripple;

    always_comb begin
        count_nxt = count;
        ripple    = en;
        // ripple carries (up) or borrows (down) until a digit absorbs it
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (ripple) begin
                if (mode) begin
                    if (count[4*i +: 4] == 4'd9) begin
                        count_nxt[4*i +: 4] = 4'd0;
                    end else begin
                        count_nxt[4*i +: 4] = count[4*i +: 4] + 4'd1;
                        ripple              = 1'b0;
                    end
                end else begin
                    if (count[4*i +: 4] == 4'd0) begin
                        count_nxt[4*i +: 4] = 4'd9;
                    end else begin
                        count_nxt[4*i +: 4] = count[4*i +: 4] - 4'd1;
                        ripple              = 1'b0;
                    end
                end
            end
        end
        wrap_nxt = ripple;
`ifdef MDC_LOAD_EN
        if (load) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                count_nxt[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
            end
            wrap_nxt = 1'b0;
        end
`endif
    end

`ifndef MDC_LOAD_EN
    logic unused_load;
    assign unused_load = ^{load, load_val};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            zero  <= 1'b1;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            zero  <= (count_nxt == '0);
            wrap  <= wrap_nxt;
        end
    end
endmodule

// File: tb/tb_multi_digit_counter.sv
// Bench for multi_digit_counter: integer-valued reference model, per-cycle compare, directed and random stimulus.
module tb_multi_digit_counter;
    localparam int unsigned N   = 2;
    localparam int unsigned MOD = 100;

    logic           clk = 1'b0;
    logic           rst_n, en, mode, load;
    logic [4*N-1:0] load_val, count;
    logic           zero, wrap;

    int  checks = 0;
    int  errors = 0;
    bit  auto_on = 1'b0;
    int unsigned mval = 0;
    bit  mwrap = 1'b0;

    multi_digit_counter #(.NUM_DIGITS(N)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .count(count), .zero(zero), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [4*N-1:0] to_bcd(int unsigned v);
        logic [4*N-1:0] b;
        int unsigned    p;
        b = '0;
        p = 1;
        for (int i = 0; i < N; i++) begin
            b[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return b;
    endfunction

    function automatic int unsigned from_bcd_clamped(logic [4*N-1:0] b);
        int unsigned v, p, d;
        v = 0;
        p = 1;
        for (int i = 0; i < N; i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the count is a plain integer modulo 10^N
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mval  = 0;
            mwrap = 1'b0;
        end else begin
            mwrap = 1'b0;
`ifdef MDC_LOAD_EN
            if (load) mval = from_bcd_clamped(load_val);
            else
`endif
            if (en) begin
                if (mode) begin
                    mwrap = (mval == MOD - 1);
                    mval  = (mval + 1) % MOD;
                end else begin
                    mwrap = (mval == 0);
                    mval  = (mval + MOD - 1) % MOD;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (auto_on) begin
            check("model_count", 32'(count), 32'(to_bcd(mval)));
            check("model_zero", 32'(zero), 32'(mval == 0));
            check("model_wrap", 32'(wrap), 32'(mwrap));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_count", 32'(count), 32'h00);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_wrap", 32'(wrap), 32'd0);

        // full up-count cycle 00..99..00
        rst_n = 1'b1; mode = 1'b1; en = 1'b1; auto_on = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k == 1) begin
                check("up_first", 32'(count), 32'h01);
                check("up_first_zero", 32'(zero), 32'd0);
            end
            if (k == 10) check("up_carry", 32'(count), 32'h10);
            if (k == 99) begin
                check("up_99", 32'(count), 32'h99);
                check("up_99_wrap", 32'(wrap), 32'd0);
            end
            if (k == 100) begin
                check("up_wrap_count", 32'(count), 32'h00);
                check("up_wrap_pulse", 32'(wrap), 32'd1);
                check("up_wrap_zero", 32'(zero), 32'd1);
            end
        end
        en = 1'b0;
        step();
        check("hold_after_wrap", 32'(wrap), 32'd0);

        // down from reset
        reset_pulse();
        mode = 1'b0; en = 1'b1;
        step();
        check("down_wrap_count", 32'(count), 32'h99);
        check("down_wrap_pulse", 32'(wrap), 32'd1);
        check("down_wrap_zero", 32'(zero), 32'd0);
        step();
        check("down_98", 32'(count), 32'h98);
        check("down_98_wrap", 32'(wrap), 32'd0);

`ifdef MDC_LOAD_EN
        load = 1'b1; load_val = 8'h3C;
        step();
        check("load_clamp", 32'(count), 32'h39);
        check("load_no_wrap", 32'(wrap), 32'd0);
        load = 1'b0; mode = 1'b1;
        step();
        check("load_then_up", 32'(count), 32'h40);
        load = 1'b1; load_val = 8'hFA;
        step();
        check("load_clamp_both", 32'(count), 32'h99);
        load = 1'b0;
        step();
        check("load_then_wrap", 32'(wrap), 32'd1);
`else
        load = 1'b1; load_val = 8'h12; mode = 1'b1;
        step();
        check("load_ignored", 32'(count), 32'h99);
        load = 1'b0;
`endif

        // enable hold with mode toggling
        reset_pulse();
        mode = 1'b1; en = 1'b1;
        repeat (57) step();
        check("reach_57", 32'(count), 32'h57);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mode = ~mode;
            step();
            check("hold_57", 32'(count), 32'h57);
            check("hold_wrap", 32'(wrap), 32'd0);
        end
        en = 1'b1; mode = 1'b0;
        step();
        check("hold_then_down", 32'(count), 32'h56);

        // asynchronous reset between edges
        mode = 1'b1;
        repeat (17) step();
        check("reach_73", 32'(count), 32'h73);
        #2 rst_n = 1'b0;
        #1;
        check("async_count", 32'(count), 32'h00);
        check("async_zero", 32'(zero), 32'd1);
        check("async_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("after_release", 32'(count), 32'h01);

        // randomized run
        for (int k = 0; k < 3000; k++) begin
            en   = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 1) == 1;
            load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 8'h99;
                1:       load_val = 8'h00;
                default: load_val = 8'($urandom);
            endcase
            if ($urandom_range(0, 99) == 0) reset_pulse();
            step();
        end

        auto_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
